instr_fetch_buffer: RTL and testbench
=====================================

# instr_fetch_buffer

Multi-cycle instruction fetch front end that feeds the processor's decode/execute datapath. Reads the byte-wide instruction memory one byte per cycle, assembles four bytes big-endian into a 32-bit instruction, and queues each instruction with its PC in a small FIFO. The execute stage consumes instructions through a valid/ready handshake. A redirect input (branch, jump, jalpc, baln) flushes the queue and restarts fetch at a new PC.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- ADDR_W, 5, instruction-memory byte-address width (32 bytes)
- RESET_PC, 32'h0, fetch PC after reset
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR_W  byte address to instruction memory; combinational
- imem_data  in  8  byte returned combinationally for imem_addr in the same cycle
- inst_valid  out  1  head entry valid
- inst_ready  in  1  consumer accepts head this cycle
- inst_word  out  32  head instruction
- inst_pc  out  32  head instruction's PC
- redirect_valid  in  1  flush and restart
- redirect_pc  in  32  new fetch PC
- misalign  out  1  sticky misaligned-redirect flag; present only with FETCH_ALIGN_CHECK_EN

## Operation
- State: fetch_pc[31:0], byte_cnt[1:0], shift register asm[23:0], FSM {FETCH, HOLD}, FIFO of {word, pc}, count[$clog2(DEPTH):0].
- imem_addr = fetch_pc[ADDR_W-1:0] + byte_cnt, wrapping mod 2^ADDR_W.
- FETCH: each cycle, capture imem_data; byte 0 goes to bits 31:24 … byte 3 to bits 7:0. byte_cnt increments.
- On byte 3, word = {asm, imem_data}:
  - If the FIFO has room (count<DEPTH) or a pop occurs in the same cycle, push {word, fetch_pc}, add 4 to fetch_pc (full 32-bit, wraps at 2^32), set byte_cnt=0, and stay in FETCH.
  - Otherwise latch the word into a hold register and go to HOLD.
- HOLD: no memory reads; imem_addr holds fetch_pc[ADDR_W-1:0]. On the first cycle with count<DEPTH or a pop, push the held word, add 4 to fetch_pc, and return to FETCH.
- Pop occurs when inst_valid && inst_ready. inst_valid = (count!=0).
- Simultaneous push and pop leaves count unchanged. Push+pop when full is legal.
- Redirect has priority over everything in its cycle:
  - count=0, byte_cnt=0, FSM=FETCH, hold register discarded.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - The same-cycle pop and push are both dropped.
- Reset values: fetch_pc=RESET_PC, byte_cnt=0, FSM=FETCH, count=0, inst_valid=0, inst_word=0, inst_pc=0, misalign=0. FIFO storage is not reset.
- Reset asserted mid-word or mid-HOLD aborts immediately; no partial word survives.

## Timing
- Fetch latency: 4 cycles per word. The word becomes visible on inst_valid on the cycle after its 4th byte edge.
- After rst_n deassert, the first inst_valid is high after the 4th posedge.
- Peak throughput: 1 instruction per 4 cycles.
- Redirect at edge N: inst_valid=0 from N through N+3; imem_addr=redirect_pc[ADDR_W-1:0] in the cycle after N; first new word valid after edge N+4.
- inst_word/inst_pc are stable while inst_valid && !inst_ready.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]!=0 sets misalign, which stays high until reset.
  - That redirect is otherwise ignored: no flush, fetch continues.
- Undefined: the misalign port is absent, and redirect_pc[1:0] is silently forced to 2'b00.

## Structure
- Package fetch_pkg: FSM state enum (FETCH, HOLD), the fetch_entry_t struct {word[31:0], pc[31:0]}, and the PC_STEP=4 constant.
- Sub-module fetch_fifo:
  - Parameter DEPTH; ports push, pop, flush, din/dout of fetch_entry_t, count, full, empty.
  - Circular read/write pointers that wrap mod DEPTH.
  - flush has priority over push/pop.
- The top level contains the byte assembler and FSM.

## Test plan
- Reset release, memory bytes 00..1F = 8C,01,00,00,AC,22,00,04,… with inst_ready=1 → after edge 4: inst_word=8C010000, inst_pc=0; after edge 8: AC220004, pc=4.
- inst_ready=0 for 40 cycles (DEPTH=4) → count reaches 4, FSM enters HOLD with the 5th word held, and imem_addr is frozen at 5'h10. Then a single pop → the held word (pc=0x10) is pushed in the same cycle, and count stays 4.
- Full FIFO, with inst_ready=1 on the same edge the 4th byte lands → the push+pop is accepted, count stays 4, and no HOLD entry occurs.
- Redirect to 0x14 mid-word (byte_cnt=2), with 2 entries queued → inst_valid=0 next cycle and imem_addr=5'h14. The first valid word has inst_pc=0x14 and is assembled from bytes 14..17.
- fetch_pc=0x1C → next word pc=0x20, and imem_addr wraps to 5'h00..03. With RESET_PC=32'hFFFFFFFC, fetch_pc wraps to 0.
- With FETCH_ALIGN_CHECK_EN, redirect_pc=0x06 → misalign=1, the queue is retained, and fetch continues sequentially. Without the macro, the same stimulus fetches from 0x04.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch buffer.
//   fetch_state_e  - assembler FSM state (FETCH: reading bytes, HOLD: word
//                    assembled but queue full)
//   fetch_entry_t  - one queued instruction {word, pc}
//   PC_STEP        - byte distance between consecutive instructions
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// instr_fetch_buffer_if: bundles the instruction-memory port, the
// instruction valid/ready stream and the redirect request.
//   imem_addr/imem_data       byte-wide instruction memory (combinational read)
//   inst_valid/ready/word/pc  queued instruction handed to execute
//   redirect_valid/pc         flush and restart request
//   misalign                  sticky flag, only when FETCH_ALIGN_CHECK_EN is defined
// Modports: master = fetch buffer, slave = memory/execute/redirect side.
interface instr_fetch_buffer_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_word;
    logic [31:0]       inst_pc;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic              misalign;

    modport master (
        output imem_addr, inst_valid, inst_word, inst_pc, misalign,
        input  imem_data, inst_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  imem_addr, inst_valid, inst_word, inst_pc, misalign,
        output imem_data, inst_ready, redirect_valid, redirect_pc
    );
`else
    modport master (
        output imem_addr, inst_valid, inst_word, inst_pc,
        input  imem_data, inst_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  imem_addr, inst_valid, inst_word, inst_pc,
        output imem_data, inst_ready, redirect_valid, redirect_pc
    );
`endif
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular queue of fetch_entry_t with a combinational head.
//   clk, rst_n   clock, asynchronous active-low reset
//   push, din    enqueue din (accepted when not full, or full with a pop)
//   pop, dout    dequeue head; dout is the current head entry
//   flush        empty the queue; wins over push and pop
//   count        number of stored entries (0..DEPTH)
//   full, empty  status
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    fetch_entry_t     mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates visibility, so stale data is never seen.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: byte-serial instruction fetch front end.
// Reads one instruction byte per cycle, assembles four bytes big-endian into
// a 32-bit word and queues {word, pc} in fetch_fifo for the execute stage.
// A redirect flushes the queue and restarts fetch at the aligned new PC.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         instr_fetch_buffer_if.master (memory, instruction stream, redirect)
// Optional: FETCH_ALIGN_CHECK_EN - unaligned redirects are ignored and set the
// sticky misalign flag instead of being silently aligned.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_buffer_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [1:0]   byte_cnt_q, byte_cnt_d;
    logic [23:0]  asm_q, asm_d;
    logic [31:0]  hold_q, hold_d;

    logic             redirect_take;
    logic             pop, push, flush, room;
    logic [31:0]      push_word, new_word;
    fetch_entry_t     head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d, misalign_hit;

    assign misalign_hit  = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    assign redirect_take = bus.redirect_valid && !misalign_hit;
    assign misalign_d    = misalign_q || misalign_hit;
    assign bus.misalign  = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
`else
    assign redirect_take = bus.redirect_valid;
`endif

    // HOLD parks the address on the held word's PC; no bytes are read there.
    assign bus.imem_addr = (state_q == HOLD) ? fetch_pc_q[ADDR_W-1:0]
                                             : fetch_pc_q[ADDR_W-1:0] + ADDR_W'(byte_cnt_q);

    assign bus.inst_valid = !fifo_empty;
    assign bus.inst_word  = fifo_empty ? 32'h0 : head.word;
    assign bus.inst_pc    = fifo_empty ? 32'h0 : head.pc;

    // A redirect drops the same-cycle pop as well as the push.
    assign pop      = bus.inst_valid && bus.inst_ready && !redirect_take;
    assign room     = !fifo_full || pop;
    assign new_word = {asm_q, bus.imem_data};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        hold_d     = hold_q;
        push       = 1'b0;
        push_word  = hold_q;
        flush      = 1'b0;

        case (state_q)
            FETCH: begin
                asm_d      = {asm_q[15:0], bus.imem_data};
                byte_cnt_d = byte_cnt_q + 2'd1;  // wraps to 0 after byte 3
                if (byte_cnt_q == 2'd3) begin
                    if (room) begin
                        push       = 1'b1;
                        push_word  = new_word;
                        fetch_pc_d = fetch_pc_q + PC_STEP;
                    end else begin
                        hold_d  = new_word;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (room) begin
                    push       = 1'b1;
                    push_word  = hold_q;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        if (redirect_take) begin
            flush      = 1'b1;
            push       = 1'b0;
            state_d    = FETCH;
            byte_cnt_d = 2'd0;
            fetch_pc_d = bus.redirect_pc & ~32'h3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            byte_cnt_q <= 2'd0;
            asm_q      <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            hold_q     <= hold_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ('{word: push_word, pc: fetch_pc_q}),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Status flags must agree with the occupancy count.
    assert property (@(posedge clk) disable iff (!rst_n)
        (fifo_empty == (fifo_count == '0)) && (fifo_full == (fifo_count == CNT_W'(DEPTH))));
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: directed scenarios plus randomized ready/redirect/
// reset traffic, checked every cycle against a transaction-level model
// (queue of {word, pc}, current fetch PC, cycles spent on the current word).
// Honours FETCH_ALIGN_CHECK_EN the same way the design does.
module tb_instr_fetch_buffer;
    import fetch_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_buffer_if #(.ADDR_W(ADDR_W)) bus ();

    instr_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [32];
    assign bus.imem_data = mem[bus.imem_addr];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    fetch_entry_t q[$];
    logic [31:0]  m_pc;
    int           m_phase;   // cycles already spent reading the current word
    bit           m_held;    // word complete but waiting for queue space
    bit           m_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [4:0] a;
        a = pc[4:0];
        return {mem[a], mem[a + 5'd1], mem[a + 5'd2], mem[a + 5'd3]};
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc    = 32'h0;
        m_phase = 0;
        m_held  = 1'b0;
        m_mis   = 1'b0;
    endtask

    // One clock edge of architectural behaviour, using the inputs present at the edge.
    task automatic model_edge();
        bit take;
        bit popped;
        int size_before;
        take = bus.redirect_valid;
`ifdef FETCH_ALIGN_CHECK_EN
        if (bus.redirect_valid && bus.redirect_pc[1:0] != 2'b00) begin
            m_mis = 1'b1;
            take  = 1'b0;
        end
`endif
        if (take) begin
            q.delete();
            m_pc    = {bus.redirect_pc[31:2], 2'b00};
            m_phase = 0;
            m_held  = 1'b0;
            return;
        end
        size_before = q.size();
        popped = (size_before > 0) && bus.inst_ready;
        if (popped) void'(q.pop_front());
        if (m_held || m_phase == 3) begin
            if (size_before < DEPTH || popped) begin
                q.push_back('{word: word_at(m_pc), pc: m_pc});
                m_pc    = m_pc + 32'd4;
                m_phase = 0;
                m_held  = 1'b0;
            end else begin
                m_held = 1'b1;
            end
        end else begin
            m_phase++;
        end
    endtask

    task automatic compare_all();
        logic [4:0] ea;
        ea = m_held ? m_pc[4:0] : m_pc[4:0] + 5'(m_phase);
        check("inst_valid", 32'(bus.inst_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("inst_word", bus.inst_word, q[0].word);
            check("inst_pc", bus.inst_pc, q[0].pc);
        end
        check("imem_addr", 32'(bus.imem_addr), 32'(ea));
`ifdef FETCH_ALIGN_CHECK_EN
        check("misalign", 32'(bus.misalign), 32'(m_mis));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Called from a negedge; asserting mid-word must abort it.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        model_reset();
        #1;
        check("rst_valid", 32'(bus.inst_valid), 32'h0);
        check("rst_word", bus.inst_word, 32'h0);
        check("rst_pc", bus.inst_pc, 32'h0);
        check("rst_addr", 32'(bus.imem_addr), 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst_misalign", 32'(bus.misalign), 32'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        cycle();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] plan [8];
        plan = '{8'h8C, 8'h01, 8'h00, 8'h00, 8'hAC, 8'h22, 8'h00, 8'h04};
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) mem[i] = plan[i];
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // Reset release and first two words
        do_reset();
        repeat (4) cycle();
        check("w0_word", bus.inst_word, 32'h8C010000);
        check("w0_pc", bus.inst_pc, 32'h0);
        repeat (4) cycle();
        check("w1_word", bus.inst_word, 32'hAC220004);
        check("w1_pc", bus.inst_pc, 32'h4);

        // Stall until HOLD, then a single pop releases the held word
        do_reset();
        bus.inst_ready = 1'b0;
        repeat (40) cycle();
        check("hold_addr", 32'(bus.imem_addr), 32'h10);
        bus.inst_ready = 1'b1;
        cycle();
        bus.inst_ready = 1'b0;
        check("hold_pop_pc", bus.inst_pc, 32'h4);
        cycle();
        check("hold_resume_addr", 32'(bus.imem_addr), 32'h15);

        // Full queue, pop on the same edge as byte 3: no HOLD
        do_reset();
        bus.inst_ready = 1'b0;
        repeat (19) cycle();
        bus.inst_ready = 1'b1;
        cycle();
        bus.inst_ready = 1'b0;
        check("nohold_addr", 32'(bus.imem_addr), 32'h14);
        check("nohold_pc", bus.inst_pc, 32'h4);

        // Redirect mid-word with two entries queued
        do_reset();
        repeat (10) cycle();
        redirect(32'h14);
        check("redir_valid", 32'(bus.inst_valid), 32'h0);
        check("redir_addr", 32'(bus.imem_addr), 32'h14);
        bus.inst_ready = 1'b1;
        repeat (3) cycle();
        check("redir_gap", 32'(bus.inst_valid), 32'h0);
        cycle();
        check("redir_pc", bus.inst_pc, 32'h14);
        check("redir_word", bus.inst_word, {mem[20], mem[21], mem[22], mem[23]});

        // Address wrap at 0x1C and 32-bit PC wrap
        redirect(32'h1C);
        repeat (4) cycle();
        check("wrap_pc0", bus.inst_pc, 32'h1C);
        repeat (4) cycle();
        check("wrap_pc1", bus.inst_pc, 32'h20);
        check("wrap_word", bus.inst_word, {mem[0], mem[1], mem[2], mem[3]});
        redirect(32'hFFFF_FFFC);
        repeat (8) cycle();
        check("pc32_wrap", bus.inst_pc, 32'h0);

        // Unaligned redirect
        do_reset();
        bus.inst_ready = 1'b0;
        repeat (9) cycle();
        redirect(32'h06);
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_flag", 32'(bus.misalign), 32'h1);
        check("mis_keep", bus.inst_pc, 32'h0);
`else
        check("mis_align_addr", 32'(bus.imem_addr), 32'h04);
`endif
        repeat (8) cycle();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            bus.inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 31) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = $urandom;
                cycle();
                bus.redirect_valid = 1'b0;
            end else begin
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
